// File: rtl/b16_arb_pkg.sv
// b16_arb_pkg: shared definitions for the b16 memory arbiter.
//   - FSM state encoding (IDLE/BUSY/DONE)
//   - winner encoding (CPU/DBG), which also serves as the last-winner value
//   - dbg_status bit positions
//   - req_t: one requester's latched access, plus a pending helper
package b16_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic WIN_CPU = 1'b0;
  localparam logic WIN_DBG = 1'b1;

  localparam int STAT_HALT = 0;
  localparam int STAT_ACK  = 1;
  localparam int STAT_TO   = 2;

  typedef struct packed {
    logic        r;
    logic [1:0]  wr;
    logic [14:0] addr;
    logic [15:0] wdata;
  } req_t;

  function automatic logic req_pending(input req_t q);
    return q.r | (|q.wr);
  endfunction

endpackage

// File: rtl/b16_arb_pick.sv
// b16_arb_pick: combinational winner select for b16_mem_arb.
// Macro: B16_ARB_RR_EN -- when defined, both-pending ties go to the requester
// that did not win last (last_win port present); otherwise debugger first.
// Ports:
//   cpu_pend  in   CPU has a request (r or any wr)
//   dbg_pend  in   debugger has a request
//   dbg_halt  in   blocks CPU eligibility
//   last_win  in   previous winner (round-robin build only)
//   grant     out  some eligible requester is pending
//   win       out  selected requester (WIN_CPU / WIN_DBG)
module b16_arb_pick
  import b16_arb_pkg::*;
(
  input  logic cpu_pend,
  input  logic dbg_pend,
  input  logic dbg_halt,
`ifdef B16_ARB_RR_EN
  input  logic last_win,
`endif
  output logic grant,
  output logic win
);

  logic cpu_ok;

  always_comb begin
    cpu_ok = cpu_pend & ~dbg_halt;
    grant  = cpu_ok | dbg_pend;
    win    = dbg_pend ? WIN_DBG : WIN_CPU;
`ifdef B16_ARB_RR_EN
    if (cpu_ok && dbg_pend) begin
      win = (last_win == WIN_DBG) ? WIN_CPU : WIN_DBG;
    end
`endif
  end

endmodule

// File: rtl/b16_mem_arb.sv
// b16_mem_arb: shares the b16 single-port RAM between the CPU bus and the
// UART debugger bus. One access at a time is latched, the RAM handshake is
// sequenced with wait states and a timeout, and a one-cycle ack is returned.
// Macro: B16_ARB_RR_EN selects round-robin arbitration (see b16_arb_pick).
// Parameter: TO_W -- timeout counter width; an access is abandoned after
//   2^TO_W-1 BUSY cycles without mem_ready.
// Ports:
//   clk, nreset                    clock, async active-low reset
//   cpu_r/cpu_wr/cpu_addr/cpu_wdata CPU request (wr[1] = high byte)
//   cpu_ack                        one-cycle CPU completion pulse
//   dbg_r/dbg_wr/dbg_addr/dbg_wdata debugger request
//   dbg_halt                       blocks new CPU grants
//   dbg_status                     {5'b0, timeout, dbg_ack, halted}
//   rdata                          read data, valid while an ack is high
//   mem_cs/mem_r/mem_wr/mem_addr/mem_wdata  RAM request (word address)
//   mem_rdata, mem_ready           RAM response
//
// state | meaning
// IDLE  | waiting for a pending request; grants and latches the winner
// BUSY  | mem_* held, waiting for mem_ready or timeout
// DONE  | ack high for this cycle; requests ignored
module b16_mem_arb
  import b16_arb_pkg::*;
#(
  parameter int TO_W = 8
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        cpu_r,
  input  logic [1:0]  cpu_wr,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  input  logic        dbg_r,
  input  logic [1:0]  dbg_wr,
  input  logic [15:0] dbg_addr,
  input  logic [15:0] dbg_wdata,
  input  logic        dbg_halt,
  output logic [7:0]  dbg_status,
  output logic [15:0] rdata,
  output logic        mem_cs,
  output logic        mem_r,
  output logic [1:0]  mem_wr,
  output logic [14:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
  localparam logic [TO_W-1:0] TO_LAST = {TO_W{1'b1}} - TO_ONE;

  logic [1:0]      state_q, state_d;
  logic            winner_q, winner_d;
  logic            mem_cs_q, mem_cs_d;
  logic            mem_r_q, mem_r_d;
  logic [1:0]      mem_wr_q, mem_wr_d;
  logic [14:0]     mem_addr_q, mem_addr_d;
  logic [15:0]     mem_wdata_q, mem_wdata_d;
  logic [15:0]     rdata_q, rdata_d;
  logic            ack_q, ack_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_flag_q, to_flag_d;

  req_t cpu_req, dbg_req, sel_req;
  logic cpu_pend, dbg_pend;
  logic grant, pick_win;
  logic halted;
  logic unused_addr_lsb;

  // Byte-address LSB is not part of the RAM word address.
  assign unused_addr_lsb = cpu_addr[0] ^ dbg_addr[0];

  assign cpu_req  = '{r: cpu_r, wr: cpu_wr, addr: cpu_addr[15:1], wdata: cpu_wdata};
  assign dbg_req  = '{r: dbg_r, wr: dbg_wr, addr: dbg_addr[15:1], wdata: dbg_wdata};
  assign cpu_pend = req_pending(cpu_req);
  assign dbg_pend = req_pending(dbg_req);

  b16_arb_pick u_pick (
    .cpu_pend (cpu_pend),
    .dbg_pend (dbg_pend),
    .dbg_halt (dbg_halt),
`ifdef B16_ARB_RR_EN
    .last_win (winner_q),
`endif
    .grant    (grant),
    .win      (pick_win)
  );

  assign sel_req = (pick_win == WIN_DBG) ? dbg_req : cpu_req;

  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    mem_cs_d    = mem_cs_q;
    mem_r_d     = mem_r_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    ack_d       = 1'b0;
    to_cnt_d    = to_cnt_q;
    to_flag_d   = to_flag_q;

    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          winner_d    = pick_win;
          mem_cs_d    = 1'b1;
          mem_r_d     = sel_req.r;
          mem_wr_d    = sel_req.wr;
          mem_addr_d  = sel_req.addr;
          mem_wdata_d = sel_req.wdata;
          to_cnt_d    = '0;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          rdata_d  = mem_rdata;
          ack_d    = 1'b1;
          mem_cs_d = 1'b0;
          mem_r_d  = 1'b0;
          mem_wr_d = 2'b00;
          state_d  = ST_DONE;
          if (winner_q == WIN_DBG) to_flag_d = 1'b0;
        end else begin
          to_cnt_d = to_cnt_q + TO_ONE;
          // Counter steps to all ones on this edge: abandon the access.
          if (to_cnt_q == TO_LAST) begin
            rdata_d  = 16'h0000;
            ack_d    = 1'b1;
            mem_cs_d = 1'b0;
            mem_r_d  = 1'b0;
            mem_wr_d = 2'b00;
            state_d  = ST_DONE;
            if (winner_q == WIN_DBG) to_flag_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_IDLE;
      winner_q    <= WIN_CPU;
      mem_cs_q    <= 1'b0;
      mem_r_q     <= 1'b0;
      mem_wr_q    <= 2'b00;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      ack_q       <= 1'b0;
      to_cnt_q    <= '0;
      to_flag_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      mem_cs_q    <= mem_cs_d;
      mem_r_q     <= mem_r_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      to_cnt_q    <= to_cnt_d;
      to_flag_q   <= to_flag_d;
    end
  end

  // Halted unless the CPU owns an access in flight.
  assign halted = dbg_halt & ((state_q == ST_IDLE) | (winner_q != WIN_CPU));

  always_comb begin
    dbg_status            = '0;
    dbg_status[STAT_HALT] = halted;
    dbg_status[STAT_ACK]  = ack_q & (winner_q == WIN_DBG);
    dbg_status[STAT_TO]   = to_flag_q;
  end

  assign cpu_ack   = ack_q & (winner_q == WIN_CPU);
  assign rdata     = rdata_q;
  assign mem_cs    = mem_cs_q;
  assign mem_r     = mem_r_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_b16_mem_arb.sv
// Testbench for b16_mem_arb (TO_W = 4). A transaction-level model tracks the
// access in flight and is compared with the DUT every falling edge; directed
// scenarios add literal expectations.
module tb_b16_mem_arb;

  localparam int TB_TO_W  = 4;
  localparam int TO_LIMIT = (1 << TB_TO_W) - 1;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        cpu_r = 1'b0;
  logic [1:0]  cpu_wr = 2'b00;
  logic [15:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_ack;
  logic        dbg_r = 1'b0;
  logic [1:0]  dbg_wr = 2'b00;
  logic [15:0] dbg_addr = '0;
  logic [15:0] dbg_wdata = '0;
  logic        dbg_halt = 1'b0;
  logic [7:0]  dbg_status;
  logic [15:0] rdata;
  logic        mem_cs;
  logic        mem_r;
  logic [1:0]  mem_wr;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ready = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  b16_mem_arb #(.TO_W(TB_TO_W)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .cpu_r      (cpu_r),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .dbg_r      (dbg_r),
    .dbg_wr     (dbg_wr),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_halt   (dbg_halt),
    .dbg_status (dbg_status),
    .rdata      (rdata),
    .mem_cs     (mem_cs),
    .mem_r      (mem_r),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Access in flight: m_cs; completed access waiting its ack cycle: m_ack.
  logic        m_cs, m_r, m_ack, m_win, m_to;
  logic [1:0]  m_wr;
  logic [14:0] m_addr;
  logic [15:0] m_wdata, m_rdata;
  logic        m_dp, m_cp;
  int          m_busy;

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      m_cs = 0; m_r = 0; m_ack = 0; m_win = 0; m_to = 0;
      m_wr = 0; m_addr = 0; m_wdata = 0; m_rdata = 0; m_busy = 0;
    end else if (m_ack) begin
      m_ack = 0;                     // ack cycle ends; nothing granted here
    end else if (m_cs) begin
      m_busy++;
      if (mem_ready || m_busy == TO_LIMIT) begin
        m_rdata = mem_ready ? mem_rdata : 16'h0000;
        if (m_win) m_to = !mem_ready;
        m_cs  = 0;
        m_ack = 1;
      end
    end else begin
      m_dp = dbg_r | (|dbg_wr);
      m_cp = (cpu_r | (|cpu_wr)) & ~dbg_halt;
      if (m_dp || m_cp) begin
`ifdef B16_ARB_RR_EN
        m_win = (m_dp && m_cp) ? ~m_win : m_dp;
`else
        m_win = m_dp;
`endif
        if (m_win) begin
          m_r = dbg_r; m_wr = dbg_wr; m_addr = dbg_addr[15:1]; m_wdata = dbg_wdata;
        end else begin
          m_r = cpu_r; m_wr = cpu_wr; m_addr = cpu_addr[15:1]; m_wdata = cpu_wdata;
        end
        m_cs   = 1;
        m_busy = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (nreset) begin
      chk("m_mem_cs", 32'(mem_cs), 32'(m_cs));
      chk("m_cpu_ack", 32'(cpu_ack), 32'(m_ack & ~m_win));
      chk("m_dbg_status", 32'(dbg_status),
          32'({5'b0, m_to, m_ack & m_win, dbg_halt & ((~m_cs & ~m_ack) | m_win)}));
      if (m_cs) begin
        chk("m_mem_r", 32'(mem_r), 32'(m_r));
        chk("m_mem_wr", 32'(mem_wr), 32'(m_wr));
        chk("m_mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("m_mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      end
      if (m_ack) chk("m_rdata", 32'(rdata), 32'(m_rdata));
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Waits for either ack; drops all requests once the access is in flight.
  task automatic run_access(output bit got, output int busy);
    got  = 0;
    busy = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (cpu_ack || dbg_status[1]) got = 1;
      else if (mem_cs) begin
        busy++;
        cpu_r = 0; cpu_wr = 0; dbg_r = 0; dbg_wr = 0;
      end
    end
  endtask

  bit got;
  int busy;
  int cnt_a, cnt_b;
  bit first_dbg;

  initial begin
`ifdef B16_ARB_RR_EN
    first_dbg = 0;
`else
    first_dbg = 1;
`endif
    // reset state
    cyc(); cyc();
    @(negedge clk);
    chk("rst_mem_cs", 32'(mem_cs), 0);
    chk("rst_cpu_ack", 32'(cpu_ack), 0);
    chk("rst_status", 32'(dbg_status), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    cyc();
    nreset = 1;

    // 1: debugger read, RAM ready at once
    cyc();
    dbg_r = 1; dbg_addr = 16'h1234; mem_rdata = 16'hBEEF; mem_ready = 1;
    cyc();
    dbg_r = 0;
    @(negedge clk);
    chk("t1_cs", 32'(mem_cs), 1);
    chk("t1_addr", 32'(mem_addr), 32'h091A);
    chk("t1_r", 32'(mem_r), 1);
    cyc();
    @(negedge clk);
    chk("t1_dbg_ack", 32'(dbg_status[1]), 1);
    chk("t1_rdata", 32'(rdata), 32'hBEEF);
    chk("t1_cpu_ack", 32'(cpu_ack), 0);
    cyc();
    @(negedge clk);
    chk("t1_ack_one_cycle", 32'(dbg_status[1]), 0);

    // 2: both request together (debugger does read+write)
    cyc();
    cpu_wr = 2'b11; cpu_addr = 16'h0100; cpu_wdata = 16'hAAAA;
    dbg_r = 1; dbg_wr = 2'b10; dbg_addr = 16'h0200; dbg_wdata = 16'h5555;
    mem_rdata = 16'h2468;
    cyc();
    if (first_dbg) begin dbg_r = 0; dbg_wr = 0; end
    else begin cpu_wr = 0; end
    @(negedge clk);
    chk("t2_first_addr", 32'(mem_addr), first_dbg ? 32'h0100 : 32'h0080);
    cyc();
    @(negedge clk);
    chk("t2_first_ack", 32'({cpu_ack, dbg_status[1]}), first_dbg ? 32'b01 : 32'b10);
    cyc();
    @(negedge clk);
    chk("t2_done_no_regrant", 32'(mem_cs), 0);
    cyc();
    cpu_wr = 0; dbg_r = 0; dbg_wr = 0;
    @(negedge clk);
    chk("t2_second_cs", 32'(mem_cs), 1);
    chk("t2_second_addr", 32'(mem_addr), first_dbg ? 32'h0080 : 32'h0100);
    cyc();
    @(negedge clk);
    chk("t2_second_ack", 32'({cpu_ack, dbg_status[1]}), first_dbg ? 32'b10 : 32'b01);
    cyc();

    // 3: CPU low-byte write with 3 wait states; halt raised mid-access
    cyc();
    cpu_wr = 2'b01; cpu_addr = 16'h0456; cpu_wdata = 16'h1357; mem_ready = 0;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      cpu_wr = 0;
      if (k == 2) dbg_halt = 1;
      if (k == 4) mem_ready = 1;
      @(negedge clk);
      chk("t3_cs", 32'(mem_cs), 1);
      chk("t3_addr", 32'(mem_addr), 32'h022B);
      chk("t3_wr", 32'(mem_wr), 32'b01);
      chk("t3_wdata", 32'(mem_wdata), 32'h1357);
      if (k == 3) chk("t3_not_halted", 32'(dbg_status[0]), 0);
    end
    cyc();
    @(negedge clk);
    chk("t3_cpu_ack", 32'(cpu_ack), 1);
    cyc();
    dbg_halt = 0;

    // 4: halt blocks a CPU request for 20 cycles
    cyc();
    dbg_halt = 1; cpu_r = 1; cpu_addr = 16'h0010;
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      @(negedge clk);
      if (mem_cs) cnt_a++;
      if (!dbg_status[0]) cnt_b++;
    end
    chk("t4_no_grant", 32'(cnt_a), 0);
    chk("t4_halted_low", 32'(cnt_b), 0);
    cyc();
    dbg_halt = 0;
    cyc();
    cpu_r = 0;
    @(negedge clk);
    chk("t4_grant_after_release", 32'(mem_cs), 1);
    chk("t4_addr", 32'(mem_addr), 32'h0008);
    cyc();
    @(negedge clk);
    chk("t4_cpu_ack", 32'(cpu_ack), 1);
    cyc();

    // 5: debugger read times out, then a normal read clears the flag
    cyc();
    dbg_r = 1; dbg_addr = 16'h0020; mem_ready = 0; mem_rdata = 16'hFFFF;
    run_access(got, busy);
    chk("t5_ack_seen", 32'(got), 1);
    chk("t5_busy_cycles", 32'(busy), 15);
    chk("t5_rdata_zero", 32'(rdata), 0);
    chk("t5_to_flag", 32'(dbg_status[2]), 1);
    cyc();
    @(negedge clk);
    chk("t5_to_flag_held", 32'(dbg_status[2]), 1);
    cyc();
    dbg_r = 1; dbg_addr = 16'h0022; mem_ready = 1; mem_rdata = 16'hCAFE;
    run_access(got, busy);
    chk("t5b_ack_seen", 32'(got), 1);
    chk("t5b_rdata", 32'(rdata), 32'hCAFE);
    chk("t5b_to_clear", 32'(dbg_status[2]), 0);
    cyc();

    // 6: reset during BUSY
    cyc();
    cpu_r = 1; cpu_addr = 16'h0300; mem_ready = 0;
    cyc();
    cpu_r = 0;
    @(negedge clk);
    chk("t6_busy_cs", 32'(mem_cs), 1);
    cyc();
    nreset = 0;
    #1;
    chk("t6_async_cs", 32'(mem_cs), 0);
    cyc();
    nreset = 1;
    mem_ready = 1;
    cnt_a = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (cpu_ack || dbg_status[1]) cnt_a++;
    end
    chk("t6_no_ack", 32'(cnt_a), 0);
    cyc();
    dbg_wr = 2'b11; dbg_addr = 16'h0400; dbg_wdata = 16'h9ABC; mem_rdata = 16'h1111;
    run_access(got, busy);
    chk("t6_fresh_ack", 32'(got), 1);
    chk("t6_fresh_busy", 32'(busy), 1);
    chk("t6_fresh_rdata", 32'(rdata), 32'h1111);
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
